// File: rtl/stack_rr_arbiter.sv
// stack_rr_arbiter: two-requester round-robin arbiter (with burst lock) in front of one LIFO stack.
// Optional macro STACK_ARB_ERR_EN: grant push-while-full / pop-while-empty and reject them with rsp_err.
module stack_rr_arbiter #(
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_op,
  input  logic [B-1:0] req0_data,
  input  logic         req0_lock,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic         req1_op,
  input  logic [B-1:0] req1_data,
  input  logic         req1_lock,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic         rsp_op,
  output logic [B-1:0] rsp_data,
  output logic         rsp_err,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [B-1:0] stk_push_data,
  input  logic [B-1:0] stk_pop_data,
  input  logic         stk_full,
  input  logic         stk_empty
);

  // state | meaning
  // ARB   | round-robin between requesters, r_prio wins a tie
  // LOCK0 | requester 0 owns the stack until it transfers with lock=0
  // LOCK1 | requester 1 owns the stack until it transfers with lock=0
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t       r_state;
  logic         r_prio;
  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic         r_rsp_op;
  logic [B-1:0] r_rsp_data;

  logic         w_ok0, w_ok1, w_cand0, w_cand1;
  logic         w_gnt0, w_gnt1, w_gnt, w_gid, w_gop, w_glock, w_gok;
  logic [B-1:0] w_gdata;

  // ok = the stack can actually perform the operation this cycle
  assign w_ok0 = req0_valid & (req0_op ? ~stk_full : ~stk_empty);
  assign w_ok1 = req1_valid & (req1_op ? ~stk_full : ~stk_empty);

`ifdef STACK_ARB_ERR_EN
  assign w_cand0 = req0_valid;
  assign w_cand1 = req1_valid;
`else
  assign w_cand0 = w_ok0;
  assign w_cand1 = w_ok1;
`endif

  // No grants while reset is held so the stack sees no strobes during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      case (r_state)
        LOCK0:   w_gnt0 = w_cand0;
        LOCK1:   w_gnt1 = w_cand1;
        default: begin
          if (w_cand0 && w_cand1) begin
            w_gnt0 = ~r_prio;
            w_gnt1 = r_prio;
          end else begin
            w_gnt0 = w_cand0;
            w_gnt1 = w_cand1;
          end
        end
      endcase
    end
  end

  assign w_gnt   = w_gnt0 | w_gnt1;
  assign w_gid   = w_gnt1;
  assign w_gop   = w_gid ? req1_op   : req0_op;
  assign w_glock = w_gid ? req1_lock : req0_lock;
  assign w_gdata = w_gid ? req1_data : req0_data;
  assign w_gok   = w_gid ? w_ok1     : w_ok0;

  assign req0_ready    = w_gnt0;
  assign req1_ready    = w_gnt1;
  assign stk_push      = w_gnt & w_gop & w_gok;
  assign stk_pop       = w_gnt & ~w_gop & w_gok;
  assign stk_push_data = w_gnt ? w_gdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_prio      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_op    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_gnt) begin
        r_rsp_id   <= w_gid;
        r_rsp_op   <= w_gop;
        r_rsp_data <= (w_gok && !w_gop) ? stk_pop_data : '0;
        case (r_state)
          ARB: begin
            r_prio <= ~w_gid;
            if (w_glock) r_state <= w_gid ? LOCK1 : LOCK0;
          end
          default: begin
            if (!w_glock) begin
              r_prio  <= ~w_gid;
              r_state <= ARB;
            end
          end
        endcase
      end
    end
  end

`ifdef STACK_ARB_ERR_EN
  logic r_rsp_err;

  always_ff @(posedge clk) begin
    if (reset)      r_rsp_err <= 1'b0;
    else if (w_gnt) r_rsp_err <= ~w_gok;
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_op    = r_rsp_op;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_stack_rr_arbiter.sv
// tb_stack_rr_arbiter: directed scenarios plus random traffic against a queue-based stack
// and a transaction-level arbiter model.
module tb_stack_rr_arbiter;
  localparam int B     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 0, req0_op = 0, req0_lock = 0;
  logic [B-1:0] req0_data = '0;
  logic         req1_valid = 0, req1_op = 0, req1_lock = 0;
  logic [B-1:0] req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_op, rsp_err;
  logic [B-1:0] rsp_data;
  logic         stk_push, stk_pop;
  logic [B-1:0] stk_push_data;
  logic [B-1:0] stk_pop_data = '0;
  logic         stk_full = 1'b0, stk_empty = 1'b1;

  stack_rr_arbiter #(.B(B)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_push_data(stk_push_data),
    .stk_pop_data(stk_pop_data), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  always #5 clk = ~clk;

  logic [B-1:0] stk_q[$];

  // owner: -1 = nobody holds the lock
  int           m_owner = -1;
  int           m_prio  = 0;
  bit           m_init  = 0;
  bit           e_rv = 0, e_id = 0, e_op = 0, e_err = 0;
  logic [B-1:0] e_data = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check, update model, clock the stack.
  task automatic step(input bit rst,
                      input bit v0, input bit o0, input logic [B-1:0] d0, input bit l0,
                      input bit v1, input bit o1, input logic [B-1:0] d1, input bit l1,
                      output int g);
    bit full, empty, ok0, ok1, c0, c1, gop, gok, glk, sp, so;
    logic [B-1:0] gd, top, pd;
    full  = (stk_q.size() == DEPTH);
    empty = (stk_q.size() == 0);
    top   = empty ? '0 : stk_q[$];
    stk_full = full; stk_empty = empty; stk_pop_data = top;
    reset = rst;
    req0_valid = v0; req0_op = o0; req0_data = d0; req0_lock = l0;
    req1_valid = v1; req1_op = o1; req1_data = d1; req1_lock = l1;
    #1;
    if (m_init) begin
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_id",    rsp_id,    e_id);
      chk("rsp_op",    rsp_op,    e_op);
      chk("rsp_data",  rsp_data,  e_data);
      chk("rsp_err",   rsp_err,   e_err);
    end
    ok0 = v0 && (o0 ? !full : !empty);
    ok1 = v1 && (o1 ? !full : !empty);
`ifdef STACK_ARB_ERR_EN
    c0 = v0; c1 = v1;
`else
    c0 = ok0; c1 = ok1;
`endif
    g = -1;
    if (!rst) begin
      if (m_owner == 0)      g = c0 ? 0 : -1;
      else if (m_owner == 1) g = c1 ? 1 : -1;
      else if (c0 && c1)     g = m_prio;
      else if (c0)           g = 0;
      else if (c1)           g = 1;
    end
    gop = (g == 1) ? o1 : o0;
    gok = (g == 1) ? ok1 : ok0;
    glk = (g == 1) ? l1 : l0;
    gd  = (g == 1) ? d1 : d0;
    if (!rst) begin
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("stk_push", stk_push, (g >= 0) && gop && gok);
      chk("stk_pop",  stk_pop,  (g >= 0) && !gop && gok);
      chk("stk_push_data", stk_push_data, (g >= 0) ? gd : 8'h00);
    end
    if (rst) begin
      m_owner = -1; m_prio = 0;
      e_rv = 0; e_id = 0; e_op = 0; e_err = 0; e_data = '0;
      m_init = 1;
    end else if (g >= 0) begin
      e_rv = 1; e_id = (g == 1); e_op = gop; e_err = !gok;
      e_data = (gok && !gop) ? top : '0;
      if (m_owner < 0) begin
        m_prio = 1 - g;
        if (glk) m_owner = g;
      end else if (!glk) begin
        m_owner = -1;
        m_prio  = 1 - g;
      end
    end else begin
      e_rv = 0;
    end
    sp = stk_push; so = stk_pop; pd = stk_push_data;
    @(posedge clk);
    if (rst) stk_q.delete();
    else begin
      if (sp && stk_q.size() < DEPTH) stk_q.push_back(pd);
      if (so && stk_q.size() > 0)     void'(stk_q.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    int g;
    step(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g);
    step(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g);
  endtask

  initial begin
    int g, a, b;
    @(negedge clk);

    // push 0x11, 0x22, then pop returns 0x22
    do_reset();
    step(0, 1, 1, 8'h11, 0, 0, 0, 8'h00, 0, g); chk("t1_gnt_a", g, 0);
    step(0, 1, 1, 8'h22, 0, 0, 0, 8'h00, 0, g); chk("t1_gnt_b", g, 0);
    step(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, g); chk("t1_gnt_pop", g, 0);
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g);
    chk("t1_pop_data", rsp_data, 8'h22);

    // both valid every cycle: grants alternate starting with 0
    do_reset();
    a = 0; b = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'hA0 + a[7:0], 0, 1, 1, 8'hB0 + b[7:0], 0, g);
      chk("t2_alt", g, i % 2);
      if (g == 0) a++; else if (g == 1) b++;
    end
    chk("t2_size", stk_q.size(), 4);
    if (stk_q.size() == 4) begin
      chk("t2_q0", stk_q[0], 8'hA0);
      chk("t2_q1", stk_q[1], 8'hB0);
      chk("t2_q2", stk_q[2], 8'hA1);
      chk("t2_q3", stk_q[3], 8'hB1);
    end

    // req1 locked burst of three pushes while req0 waits
    do_reset();
    step(0, 0, 1, 8'h55, 0, 1, 1, 8'hC0, 1, g); chk("t3_b0", g, 1);
    step(0, 1, 1, 8'h55, 0, 1, 1, 8'hC1, 1, g); chk("t3_b1", g, 1);
    step(0, 1, 1, 8'h55, 0, 1, 1, 8'hC2, 0, g); chk("t3_b2", g, 1);
    step(0, 1, 1, 8'h55, 0, 0, 0, 8'h00, 0, g); chk("t3_rel", g, 0);

    // stack full: req1 pop goes first, then req0 push
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 8'h60 + 8'(i), 0, 0, 0, 8'h00, 0, g);
    chk("t4_full", stk_q.size(), DEPTH);
    step(0, 1, 1, 8'h77, 0, 1, 0, 8'h00, 0, g); chk("t4_first", g, 1);
    step(0, 1, 1, 8'h77, 0, 0, 0, 8'h00, 0, g); chk("t4_second", g, 0);

    // pop while empty
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, g);
`ifdef STACK_ARB_ERR_EN
      chk("t5_err_gnt", g, 0);
`else
      chk("t5_stall", g, -1);
`endif
    end
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g);

    // reset during a locked req1 grant clears lock and priority
    do_reset();
    step(0, 0, 0, 8'h00, 0, 1, 1, 8'hD0, 1, g); chk("t6_lock", g, 1);
    step(1, 0, 0, 8'h00, 0, 1, 1, 8'hD1, 1, g);
    step(0, 1, 1, 8'h90, 0, 1, 1, 8'hD2, 0, g); chk("t6_after", g, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 7), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
           g);
    end
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stack_rr_arbiter.md
Name: stack_rr_arbiter

Overview:
- Shares one LIFO stack (B-bit words, full/empty flags, combinational top-of-stack read) between two requesters.
- Requesters use valid/ready push/pop requests. The arbiter grants at most one per cycle, round-robin, with an optional lock for atomic multi-word bursts.
- It drives the stack's push/pop/push_data and returns a registered response one cycle after each grant.
- Sits directly in front of the stack; the stack uses the same clk/reset.

Parameters:
- B, 8, data word width; must match the stack word width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_op  in  1  1=push, 0=pop
- req0_data  in  B  push data (ignored for pop)
- req0_lock  in  1  keep ownership after this transaction
- req0_ready  out  1  grant to requester 0; transfer when valid&ready
- req1_valid, req1_op, req1_data, req1_lock, req1_ready  same as above for requester 1
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester that owns the response
- rsp_op  out  1  op of the completed transaction
- rsp_data  out  B  popped word; 0 for push
- rsp_err  out  1  request rejected (see Optional Feature); 0 otherwise
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_push_data  out  B  stack write data
- stk_pop_data  in  B  stack top-of-stack word (combinational, valid when not empty)
- stk_full  in  1  stack full flag
- stk_empty  in  1  stack empty flag

Behaviour:
- State register: ARB, LOCK0, LOCK1. Priority pointer prio (1 bit) = requester favoured on a tie.
- Reset values: state=ARB, prio=0, rsp_valid=0, rsp_id=0, rsp_op=0, rsp_data=0, rsp_err=0.
  - Combinational outputs with no valid request: req*_ready=0, stk_push=0, stk_pop=0, stk_push_data=0.
- Eligibility of reqN: reqN_valid, and (op=push and !stk_full, or op=pop and !stk_empty).
  - An ineligible request is not granted and waits; ready stays 0.
- Grant (combinational from the registered state and the inputs):
  - In ARB: one eligible requester gets the grant. If both are eligible, the prio requester is granted.
  - In LOCKn: only requester n may be granted; the other requester's ready is forced to 0.
  - At most one ready is high per cycle.
- Stack drive in the grant cycle:
  - stk_push = granted & op=push; stk_pop = granted & op=pop.
  - stk_push_data = granted reqN_data, else 0.
  - stk_push and stk_pop are never both 1.
- Response, one cycle after the grant:
  - rsp_valid=1, rsp_id=granted index, rsp_op=op.
  - rsp_data = stk_pop_data sampled in the grant cycle for a pop, 0 for a push.
  - Cycles without a grant: rsp_valid=0; the other rsp fields hold.
- After any grant in ARB, prio = other requester.
- State transitions:
  - ARB -> LOCKn when requester n is granted with reqN_lock=1.
  - LOCKn -> ARB on a grant to n with reqN_lock=0; prio = other requester.
  - LOCKn stays in LOCKn otherwise, including while the owner is ineligible or idle. This is a deadlock hazard by design; the owner is responsible for releasing the lock.
- Throughput: one transaction per cycle; back-to-back grants are allowed.
- Empty/full are read from the stack's registered flags, so a pop granted in the cycle after a final push sees empty=0 and is legal.
- Mid-operation reset:
  - A response pending for the next cycle is dropped (rsp_valid=0).
  - Any lock is cleared.
  - Requesters re-present their requests after reset deasserts.

Optional Feature:
- Macro: STACK_ARB_ERR_EN.
- Defined:
  - An ineligible valid request (push while full, pop while empty) is eligible for arbitration under the same round-robin/lock rules.
  - When granted, ready=1 but no stack strobe is issued.
  - The response has rsp_err=1 and rsp_data=0.
  - A locked owner that is rejected keeps the lock if its lock=1.
- Undefined: ineligible requests wait (stall); rsp_err is tied 0.

Test Plan:
- Reset, then req0 pushes 0x11, 0x22 back-to-back with the stack empty -> stk_push high 2 cycles; rsp_valid pulses with id=0, op=1, data=0; next req0 pop -> rsp_data=0x22.
- Both requesters valid every cycle (req0 push 0xA0.., req1 push 0xB0..) -> grants alternate 0,1,0,1 starting with 0 after reset; stack holds 0xA0,0xB0,0xA1,0xB1.
- req1 issues 3 pushes with lock=1,1,0 while req0 is continuously valid -> req0_ready=0 throughout; three consecutive req1 grants; req0 granted on the next cycle.
- Stack full, req0 push valid, req1 pop valid -> req1 granted first; req0 granted the cycle after (the stack is no longer full).
- Stack empty, req0 pop valid, ERR_EN off -> req0_ready stays 0 for 10 cycles, no strobes. ERR_EN on -> granted in 1 cycle, rsp_err=1, stk_pop=0.
- Assert reset while req1 is granted with lock=1 -> next cycle rsp_valid=0, state ARB, prio=0, req0 and req1 both valid -> req0 granted.
